// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// After reset the RAM is swept to zero, then A/B requests are granted
// alternately when both are pending; reads return data one cycle later.
module ram_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int ADDR_BUS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_BUS-1:0] a_addr,
  input  logic [WIDTH-1:0]    a_din,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_BUS-1:0] b_addr,
  input  logic [WIDTH-1:0]    b_din,
  output logic                a_gnt,
  output logic                b_gnt,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [WIDTH-1:0]    a_rdata,
  output logic [WIDTH-1:0]    b_rdata,
  output logic                init_done,
  output logic                ram_we,
  output logic [ADDR_BUS-1:0] ram_addr,
  output logic [WIDTH-1:0]    ram_din,
  input  logic [WIDTH-1:0]    ram_dout
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_BUS-1:0] cnt_q, cnt_d;
  // ptr_q = 0 favours A, 1 favours B (i.e. A was granted most recently)
  logic                ptr_q, ptr_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [ADDR_BUS-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    din_q, din_d;
  logic                we_c;
  logic [ADDR_BUS-1:0] addr_c;
  logic [WIDTH-1:0]    din_c;

  // Next-state, grant and RAM-port selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    init_done  = 1'b0;
    we_c       = 1'b0;
    addr_c     = addr_q;
    din_c      = din_q;
    case (state_q)
      INIT: begin
        we_c   = 1'b1;
        addr_c = cnt_q;
        din_c  = '0;
        cnt_d  = cnt_q + ADDR_BUS'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        init_done = 1'b1;
        a_gnt     = a_req & (~b_req | ~ptr_q);
        b_gnt     = b_req & ~a_gnt;
        if (a_gnt) begin
          we_c       = a_we;
          addr_c     = a_addr;
          din_c      = a_din;
          ptr_d      = 1'b1;
          a_rvalid_d = ~a_we;
        end else if (b_gnt) begin
          we_c       = b_we;
          addr_c     = b_addr;
          din_c      = b_din;
          ptr_d      = 1'b0;
          b_rvalid_d = ~b_we;
        end
      end
      default: state_d = INIT;
    endcase
    // Address/data registers remember the last driven values so the RAM
    // port holds steady on idle cycles.
    addr_d = addr_c;
    din_d  = din_c;
  end

  // State, pointer, rvalid and held address/data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  // INIT drives a write every cycle, so the write strobe is gated by reset
  assign ram_we   = we_c & rst;
  assign ram_addr = addr_c;
  assign ram_din  = din_c;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of RAM words.
REQ-003 SHALL have parameter ADDR_BUS, default $clog2(DEPTH): address width (6 at default).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req / b_req  input  1  requester A/B access request, held until granted.
REQ-007 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr / b_addr  input  ADDR_BUS  word address.
REQ-009 SHALL have ports a_din / b_din  input  WIDTH  write data.
REQ-010 SHALL have ports a_gnt / b_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports a_rvalid / b_rvalid  output  1  a_rdata / b_rdata valid this cycle.
REQ-012 SHALL have ports a_rdata / b_rdata  output  WIDTH  read data, equal to ram_dout.
REQ-013 SHALL have port init_done  output  1  RAM clear sweep complete.
REQ-014 SHALL have ports ram_we  output  1, ram_addr  output  ADDR_BUS, ram_din  output  WIDTH  drive the single-port RAM.
REQ-015 SHALL have port ram_dout  input  WIDTH  RAM registered read data (1-cycle latency).

Function
REQ-016 SHALL implement FSM states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-017 In INIT: ram_we = 1, ram_addr = counter, ram_din = 0; counter increments each cycle; transition to RUN after the cycle addressing DEPTH-1 (DEPTH cycles total).
REQ-018 init_done SHALL be 0 in INIT and 1 in RUN; a_gnt/b_gnt SHALL be 0 in INIT regardless of requests.
REQ-019 In RUN, grants SHALL be combinational from req and priority pointer; at most one grant per cycle.
REQ-020 Only one requester: grant it. Both: grant the one not granted most recently. Neither: no grant, ram_we = 0.
REQ-021 Priority pointer SHALL reset to favour A and update only on cycles with a grant.
REQ-022 ram_we/ram_addr/ram_din SHALL mirror the granted requester's we/addr/din in that cycle; with no grant ram_we = 0, ram_addr/ram_din hold their last driven values.
REQ-023 A granted read SHALL assert that requester's rvalid for exactly the following cycle; rdata SHALL equal ram_dout then.
REQ-024 A granted write SHALL produce no rvalid.
REQ-025 Accesses SHALL be performed in grant order; a read granted the cycle after a write to the same address SHALL return the new data.
REQ-026 Both writing the same address on consecutive grants: the later grant's data SHALL remain.
REQ-027 A requester holding req continuously SHALL be granted within 2 cycles in RUN (no starvation).
REQ-028 Requests held during INIT SHALL be serviced per REQ-020 from the first RUN cycle, A first if both.

Reset
REQ-029 rst low SHALL immediately force: state INIT, counter 0, pointer to A, init_done 0, a_gnt/b_gnt 0, a_rvalid/b_rvalid 0, ram_we 0 (ram_we gated by rst).
REQ-030 Reset during RUN SHALL drop any pending rvalid and restart the full clear sweep on release.
REQ-031 rdata outputs are undefined when rvalid = 0; no reset value required.

Verification
REQ-032 Release reset, no requests -> ram_we = 1 for 64 cycles addressing 0..63 with ram_din 0x00, then init_done = 1, ram_we = 0.
REQ-033 RUN, A writes 0x5A to addr 3, then A reads addr 3 -> a_gnt each cycle, a_rvalid 1 cycle after read grant, a_rdata = 0x5A.
REQ-034 RUN, a_req and b_req both held high, reads to addr 1 and 2 -> grants alternate A, B, A, B; each rvalid lands on its own requester only.
REQ-035 A writes 0x11, B writes 0x22 to addr 7 concurrently, then A reads addr 7 -> data 0x22.
REQ-036 Assert rst mid-RUN with a read grant outstanding -> a_rvalid/b_rvalid, gnt, init_done go 0 immediately; after release a new 64-cycle sweep occurs.
REQ-037 Requests held during INIT -> no gnt until init_done = 1; first RUN cycle grants A.
